// File: rtl/data_mem_pkg.sv
// Shared constants for the data-memory responder: FSM state codes and the
// fixed RAM locations of the matrix bound words.
package data_mem_pkg;

    localparam int unsigned A_LOC       = 0;
    localparam int unsigned B_LOC       = 1;
    localparam int unsigned C_LOC       = 2;
    localparam int unsigned P_START_LOC = 3;
    localparam int unsigned Q_START_LOC = 4;
    localparam int unsigned R_START_LOC = 5;
    localparam int unsigned P_END_LOC   = 6;
    localparam int unsigned Q_END_LOC   = 7;
    localparam int unsigned R_END_LOC   = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_FETCH_S = 3'd3;
    localparam logic [2:0] ST_FETCH_E = 3'd4;
    localparam logic [2:0] ST_PRIME   = 3'd5;
    localparam logic [2:0] ST_DUMP    = 3'd6;
    localparam logic [2:0] ST_FIN     = 3'd7;

endpackage

// File: rtl/data_mem_ram.sv
// Single-port synchronous RAM with registered read; read-during-write
// returns the old contents. Contents and read register are never reset.
module data_mem_ram #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: loads the RAM image from the host, serves the core
// during RUN, then streams the result matrix R back to the host.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int REG_WIDTH           = 12,
    parameter int DATA_MEM_DEPTH      = 4096,
    parameter int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] dataMemAddr,
    input  logic [REG_WIDTH-1:0]           ProcessorDataOut,
    input  logic                           DataMemWrEn,
    output logic [REG_WIDTH-1:0]           ProcessorDataIn,
    output logic                           start,
    input  logic                           done,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic                           load_last,
    input  logic [REG_WIDTH-1:0]           load_data,
    output logic                           dump_valid,
    input  logic                           dump_ready,
    output logic                           dump_last,
    output logic [REG_WIDTH-1:0]           dump_data,
    output logic                           busy
);

    localparam int AW = DATA_MEM_ADDR_WIDTH;
    localparam int RW = REG_WIDTH;

    logic [2:0]    state;
    logic [AW-1:0] load_ptr;
    logic [AW-1:0] r_start;
    logic [AW-1:0] r_end;
    logic [AW-1:0] rd_addr;
    logic          rv;
    logic          rlast;
    logic          issue_done;

    logic [RW:0]   fifo [2];
    logic          head;
    logic [1:0]    cnt;
    logic [1:0]    cnt_next;

    logic          run_d1;
    logic [RW-1:0] pdi_hold;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [RW-1:0] ram_wdata;
    logic [RW-1:0] ram_rdata;

    logic          load_fire;
    logic [AW-1:0] bound_end;
    logic [RW:0]   out_word;
    logic          out_valid;
    logic          pop;
    logic          pop_buf;
    logic          bypass;
    logic          push;
    logic          issue;

    data_mem_ram #(
        .WIDTH      (RW),
        .DEPTH      (DATA_MEM_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign load_ready = (state == ST_LOAD);
    assign start      = (state == ST_RUN);
    assign busy       = (state != ST_IDLE) && (state != ST_FIN);
    assign load_fire  = load_valid && load_ready;
    assign bound_end  = ram_rdata[AW-1:0];

    // Core read data comes straight from the RAM register only in the cycle
    // after a RUN read; otherwise the last value is replayed from pdi_hold.
    assign ProcessorDataIn = run_d1 ? ram_rdata : pdi_hold;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state)
            ST_LOAD: begin
                ram_addr  = load_ptr;
                ram_we    = load_fire;
                ram_wdata = load_data;
            end
            ST_RUN: begin
                ram_addr  = dataMemAddr;
                ram_we    = DataMemWrEn;
                ram_wdata = ProcessorDataOut;
            end
            ST_FETCH_S: ram_addr = AW'(R_START_LOC);
            ST_FETCH_E: ram_addr = AW'(R_END_LOC);
            ST_PRIME:   ram_addr = r_start;
            ST_DUMP:    ram_addr = rd_addr;
            default:    ram_addr = '0;
        endcase
    end

    // The buffer head is presented when non-empty; otherwise the word just
    // read bypasses it. Reads are issued only while a landing slot is assured.
    assign out_word   = (cnt != 2'd0) ? fifo[head] : {rlast, ram_rdata};
    assign out_valid  = (state == ST_DUMP) && ((cnt != 2'd0) || rv);
    assign dump_valid = out_valid;
    assign dump_data  = out_valid ? out_word[RW-1:0] : '0;
    assign dump_last  = out_valid && out_word[RW];

    assign pop      = out_valid && dump_ready;
    assign pop_buf  = pop && (cnt != 2'd0);
    assign bypass   = rv && (cnt == 2'd0) && pop;
    assign push     = (state == ST_DUMP) && rv && !bypass;
    assign cnt_next = cnt + {1'b0, push} - {1'b0, pop_buf};
    assign issue    = (state == ST_DUMP) && !issue_done && (cnt_next <= 2'd1);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[head ^ cnt[0]] <= {rlast, ram_rdata};
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= ST_IDLE;
            load_ptr   <= '0;
            r_start    <= '0;
            r_end      <= '0;
            rd_addr    <= '0;
            rv         <= 1'b0;
            rlast      <= 1'b0;
            issue_done <= 1'b0;
            head       <= 1'b0;
            cnt        <= '0;
            run_d1     <= 1'b0;
            pdi_hold   <= '0;
        end else begin
            run_d1   <= (state == ST_RUN);
            pdi_hold <= ProcessorDataIn;
            case (state)
                ST_IDLE: begin
                    load_ptr <= '0;
                    state    <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        load_ptr <= (load_ptr == AW'(DATA_MEM_DEPTH - 1)) ? '0 : load_ptr + 1'b1;
                        if (load_last) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (done) begin
                        state <= ST_FETCH_S;
                    end
                end
                ST_FETCH_S: state <= ST_FETCH_E;
                ST_FETCH_E: begin
                    r_start <= ram_rdata[AW-1:0];
                    state   <= ST_PRIME;
                end
                ST_PRIME: begin
                    r_end <= bound_end;
                    if (bound_end < r_start) begin
                        state <= ST_FIN;
                    end else begin
                        rv         <= 1'b1;
                        rlast      <= (r_start == bound_end);
                        issue_done <= (r_start == bound_end);
                        rd_addr    <= r_start + 1'b1;
                        head       <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    rv  <= issue;
                    cnt <= cnt_next;
                    if (issue) begin
                        rlast      <= (rd_addr == r_end);
                        issue_done <= (rd_addr == r_end);
                        rd_addr    <= rd_addr + 1'b1;
                    end
                    if (pop_buf) begin
                        head <= ~head;
                    end
                    if (pop && out_word[RW]) begin
                        state <= ST_FIN;
                    end
                end
                default: state <= ST_FIN;
            endcase
        end
    end

endmodule
